// File: rtl/spi_reg_writer_if.sv
// SPI pin and register-write strobe bundle between host/pins and the synth core.
// slave: the SPI target (spi_reg_writer); master: whatever drives the pins and consumes the strobe.
interface spi_reg_writer_if;
    logic        spi_sck_in;
    logic        spi_cs_n_in;
    logic        spi_mosi_in;
    logic        spi_miso_out;
    logic [3:0]  addr_out;
    logic [15:0] data_out;
    logic        data_valid_out;
    logic        frame_err_out;

    modport slave (
        input  spi_sck_in, spi_cs_n_in, spi_mosi_in,
        output spi_miso_out, addr_out, data_out, data_valid_out, frame_err_out
    );

    modport master (
        output spi_sck_in, spi_cs_n_in, spi_mosi_in,
        input  spi_miso_out, addr_out, data_out, data_valid_out, frame_err_out
    );
endinterface

// File: rtl/spi_reg_writer.sv
// SPI mode-0 target turning 24-bit frames into a one-clk addr/data write strobe; no backpressure.
// Strobe 2 clk after the synced 24th sck rise is detected (SYNC_STAGES+3 clk after the pin edge).
module spi_reg_writer #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [3:0]  WRITE_OPCODE = 4'h8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    spi_reg_writer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
    logic r_sck_d, r_cs_d;
    logic r_sck_rise, r_sck_fall, r_cs_rise, r_cs_fall;
    logic w_sck, w_cs_n, w_mosi;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // cs_n chain resets low so a cs_n already low at reset release never looks like a new frame
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
            r_sck_rise  <= 1'b0;
            r_sck_fall  <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_in};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
            r_sck_rise  <= w_sck & ~r_sck_d;
            r_sck_fall  <= ~w_sck & r_sck_d;
            r_cs_rise   <= w_cs_n & ~r_cs_d;
            r_cs_fall   <= ~w_cs_n & r_cs_d;
        end
    end

    state_t      r_state, w_state;
    logic [4:0]  r_bit_cnt, w_bit_cnt;
    logic [23:0] r_rx_shift, w_rx_shift;
    logic [23:0] r_tx_shift, w_tx_shift;
    logic [23:0] r_last_frame, w_last_frame;
    logic        r_miso, w_miso;
    logic [3:0]  r_addr, w_addr;
    logic [15:0] r_data, w_data;
    logic        r_valid, w_valid;
    logic        r_err, w_err;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_last_frame <= '0;
            r_miso       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_bit_cnt    <= w_bit_cnt;
            r_rx_shift   <= w_rx_shift;
            r_tx_shift   <= w_tx_shift;
            r_last_frame <= w_last_frame;
            r_miso       <= w_miso;
            r_addr       <= w_addr;
            r_data       <= w_data;
            r_valid      <= w_valid;
            r_err        <= w_err;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_bit_cnt    = r_bit_cnt;
        w_rx_shift   = r_rx_shift;
        w_tx_shift   = r_tx_shift;
        w_last_frame = r_last_frame;
        w_miso       = r_miso;
        w_addr       = r_addr;
        w_data       = r_data;
        w_valid      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cs_fall) begin
                    w_state    = SHIFT;
                    w_bit_cnt  = '0;
                    w_tx_shift = r_last_frame;
                    w_miso     = r_last_frame[23];
                end
            end
            SHIFT: begin
                // cs_n rise takes priority over any sck edge seen in the same clk
                if (r_cs_rise) begin
                    w_err   = 1'b1;
                    w_state = IDLE;
                end else if (r_sck_rise) begin
                    w_rx_shift = {r_rx_shift[22:0], w_mosi};
                    w_bit_cnt  = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd23) begin
                        w_state = DONE;
                    end
                end else if (r_sck_fall) begin
                    w_tx_shift = {r_tx_shift[22:0], 1'b0};
                    w_miso     = r_tx_shift[22];
                end
            end
            DONE: begin
                if (r_rx_shift[23:20] == WRITE_OPCODE) begin
                    w_addr       = r_rx_shift[19:16];
                    w_data       = r_rx_shift[15:0];
                    w_valid      = 1'b1;
                    w_last_frame = r_rx_shift;
                end else begin
                    w_err = 1'b1;
                end
                w_state = r_cs_rise ? IDLE : WAIT_CS;
            end
            WAIT_CS: begin
                if (r_cs_rise) begin
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.spi_miso_out   = r_miso;
    assign bus.addr_out       = r_addr;
    assign bus.data_out       = r_data;
    assign bus.data_valid_out = r_valid;
    assign bus.frame_err_out  = r_err;
endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: a host task drives SPI frames while a frame-level model predicts
// each write/error strobe, the held addr/data, the MISO readback and the strobe latency.
module tb_spi_reg_writer;
    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    always #5 clk_in = ~clk_in;

    spi_reg_writer_if bus();

    spi_reg_writer #(.SYNC_STAGES(2), .WRITE_OPCODE(4'h8)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    typedef struct packed {
        logic        is_wr;
        logic [3:0]  addr;
        logic [15:0] data;
    } ev_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise24_cyc = -100;
    int n_valid = 0;
    int n_err = 0;
    ev_t exp_q[$];
    logic [3:0]  m_addr = '0;
    logic [15:0] m_data = '0;
    logic [23:0] m_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        ev_t ev;
        if (reset_in) begin
            check("reset_outputs", {9'd0, bus.spi_miso_out, bus.addr_out, bus.data_out,
                                    bus.data_valid_out, bus.frame_err_out}, 32'd0);
        end else begin
            check("valid_err_exclusive", bus.data_valid_out & bus.frame_err_out, 0);
            if (bus.data_valid_out) begin
                n_valid++;
                check("valid_has_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("valid_kind", ev.is_wr, 1);
                    m_addr = ev.addr;
                    m_data = ev.data;
                    check("valid_latency", cyc - rise24_cyc, 5);
                end
            end
            if (bus.frame_err_out) begin
                n_err++;
                check("err_has_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("err_kind", ev.is_wr, 0);
                end
            end
            check("addr_hold", bus.addr_out, m_addr);
            check("data_hold", bus.data_out, m_data);
        end
    end

    // bits are left-aligned: bit 29 goes first; rst_at >= 0 pulses reset before that bit
    task automatic xfer(input logic [29:0] bits, input int n, input int rst_at,
                        output logic [23:0] rx);
        logic [29:0] cap;
        logic [23:0] fr;
        logic [23:0] exp_rb;
        ev_t e;
        cap    = '0;
        fr     = bits[29:6];
        exp_rb = m_last;
        if (rst_at < 0) begin
            e.is_wr = 1'b0;
            e.addr  = fr[19:16];
            e.data  = fr[15:0];
            if (n >= 24 && fr[23:20] == 4'h8) begin
                e.is_wr = 1'b1;
                m_last  = fr;
            end
            exp_q.push_back(e);
        end
        @(negedge clk_in);
        bus.spi_cs_n_in = 1'b0;
        repeat (8) @(negedge clk_in);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                @(posedge clk_in);
                #1;
                reset_in = 1'b1;
                m_addr = '0;
                m_data = '0;
                m_last = '0;
                repeat (3) @(negedge clk_in);
                @(posedge clk_in);
                #1;
                reset_in = 1'b0;
                @(negedge clk_in);
                break;
            end
            bus.spi_mosi_in = bits[29-i];
            repeat (4) @(negedge clk_in);
            cap[29-i] = bus.spi_miso_out;
            bus.spi_sck_in = 1'b1;
            if (i == 23) rise24_cyc = cyc;
            repeat (4) @(negedge clk_in);
            bus.spi_sck_in = 1'b0;
        end
        repeat (4) @(negedge clk_in);
        bus.spi_cs_n_in = 1'b1;
        bus.spi_mosi_in = 1'b0;
        repeat (12) @(negedge clk_in);
        rx = cap[29:6];
        if (rst_at < 0 && n >= 24) check("readback_model", rx, exp_rb);
    endtask

    initial begin
        logic [23:0] rb;
        int v0, e0;
        bus.spi_sck_in  = 1'b0;
        bus.spi_cs_n_in = 1'b1;
        bus.spi_mosi_in = 1'b0;
        repeat (4) @(negedge clk_in);
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        repeat (4) @(negedge clk_in);

        v0 = n_valid; e0 = n_err;
        xfer({24'h831234, 6'd0}, 24, -1, rb);
        check("t1_readback", rb, 24'h000000);
        check("t1_addr", bus.addr_out, 4'h3);
        check("t1_data", bus.data_out, 16'h1234);
        check("t1_strobes", n_valid - v0, 1);
        check("t1_errs", n_err - e0, 0);

        v0 = n_valid; e0 = n_err;
        xfer({24'h8000FF, 6'd0}, 24, -1, rb);
        xfer({24'h85A5A5, 6'd0}, 24, -1, rb);
        check("t2_readback", rb, 24'h8000FF);
        check("t2_addr", bus.addr_out, 4'h5);
        check("t2_data", bus.data_out, 16'hA5A5);
        check("t2_strobes", n_valid - v0, 2);
        check("t2_errs", n_err - e0, 0);

        v0 = n_valid; e0 = n_err;
        xfer({24'h12BEEF, 6'd0}, 24, -1, rb);
        check("t3_readback", rb, 24'h85A5A5);
        check("t3_addr", bus.addr_out, 4'h5);
        check("t3_data", bus.data_out, 16'hA5A5);
        check("t3_strobes", n_valid - v0, 0);
        check("t3_errs", n_err - e0, 1);

        v0 = n_valid; e0 = n_err;
        xfer({24'h8F1111, 6'd0}, 13, -1, rb);
        check("t4_short_strobes", n_valid - v0, 0);
        check("t4_short_errs", n_err - e0, 1);
        xfer({24'h870001, 6'd0}, 24, -1, rb);
        check("t4_readback", rb, 24'h85A5A5);
        check("t4_addr", bus.addr_out, 4'h7);
        check("t4_data", bus.data_out, 16'h0001);
        check("t4_strobes", n_valid - v0, 1);

        v0 = n_valid; e0 = n_err;
        xfer({24'h89CAFE, 6'b101101}, 30, -1, rb);
        check("t5_readback", rb, 24'h870001);
        check("t5_addr", bus.addr_out, 4'h9);
        check("t5_data", bus.data_out, 16'hCAFE);
        check("t5_strobes", n_valid - v0, 1);
        check("t5_errs", n_err - e0, 0);

        v0 = n_valid; e0 = n_err;
        xfer({24'h8F0F0F, 6'd0}, 24, 10, rb);
        check("t6_abort_strobes", n_valid - v0, 0);
        check("t6_abort_errs", n_err - e0, 0);
        check("t6_reset_addr", bus.addr_out, 4'h0);
        xfer({24'h810042, 6'd0}, 24, -1, rb);
        check("t6_readback", rb, 24'h000000);
        check("t6_addr", bus.addr_out, 4'h1);
        check("t6_data", bus.data_out, 16'h0042);
        check("t6_strobes", n_valid - v0, 1);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
